onchip_delay_ram: RTL

ONCHIP_DELAY_RAM -- requirements
Module: onchip_delay_ram

---
 rtl/onchip_delay_ram.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/onchip_delay_ram.sv
// Sample delay line on a single-port RAM: each accepted sample is written at the
// circular write pointer, then NUM_TAPS delayed words are read back one per cycle.
module onchip_delay_ram #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 11,
    parameter int NUM_TAPS = 4,
    localparam int TAP_IW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          avs_address,
    input  logic [BE_W-1:0]            avs_byteenable,
    input  logic                       avs_chipselect,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [DATA_W-1:0]          avs_writedata,
    output logic [DATA_W-1:0]          avs_readdata,
    output logic                       avs_readdatavalid,
    output logic                       avs_waitrequest,
    input  logic                       smp_valid,
    input  logic [DATA_W-1:0]          smp_data,
    output logic                       smp_ready,
    input  logic [NUM_TAPS*ADDR_W-1:0] tap_delay,
    output logic                       tap_valid,
    output logic [TAP_IW-1:0]          tap_index,
    output logic [DATA_W-1:0]          tap_data,
    output logic [ADDR_W-1:0]          wr_ptr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_TAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TAP_IW-1:0] K_LAST = TAP_IW'(NUM_TAPS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [TAP_IW-1:0]   r_k;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [DATA_W-1:0]   r_smp;
    logic [ADDR_W-1:0]   r_delay [NUM_TAPS];
    logic [DATA_W-1:0]   r_mem [2**ADDR_W];

    logic                r_tap_valid;
    logic [TAP_IW-1:0]   r_tap_index;
    logic [DATA_W-1:0]   r_tap_data;
    logic                r_avs_rdv;
    logic [DATA_W-1:0]   r_avs_rdata;

    logic                w_avs_cmd;
    logic                w_avs_acc;
    logic                w_avs_wr;
    logic                w_avs_rd;
    logic                w_tap_rd;
    logic [ADDR_W-1:0]   w_tap_addr;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_we;
    logic [BE_W-1:0]     w_ram_be;
    logic [DATA_W-1:0]   w_ram_wdata;

    // Samples win over the bus: Avalon only gets through in an idle cycle with no sample offered.
    assign w_avs_cmd  = avs_chipselect & (avs_read | avs_write);
    assign w_avs_acc  = (r_state == S_IDLE) & ~smp_valid & w_avs_cmd;
    assign w_avs_wr   = w_avs_acc & avs_write;
    assign w_avs_rd   = w_avs_acc & avs_read & ~avs_write;
    assign w_tap_rd   = (r_state == S_TAP);
    assign w_tap_addr = r_wr_ptr - r_delay[r_k];

    assign smp_ready         = (r_state == S_IDLE);
    assign avs_waitrequest   = w_avs_cmd & ~w_avs_acc;
    assign tap_valid         = r_tap_valid;
    assign tap_index         = r_tap_index;
    assign tap_data          = r_tap_data;
    assign avs_readdatavalid = r_avs_rdv;
    assign avs_readdata      = r_avs_rdata;
    assign wr_ptr            = r_wr_ptr;

    // Next-state logic of the sample sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (smp_valid) begin
                    w_next = S_WR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WR:   w_next = S_TAP;
            S_TAP: begin
                if (r_k == K_LAST) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_TAP;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Single RAM port: sample write, tap read, or Avalon access share one address.
    always_comb begin
        w_ram_addr  = avs_address;
        w_ram_we    = 1'b0;
        w_ram_be    = {BE_W{1'b0}};
        w_ram_wdata = avs_writedata;
        case (r_state)
            S_WR: begin
                w_ram_addr  = r_wr_ptr;
                w_ram_we    = 1'b1;
                w_ram_be    = {BE_W{1'b1}};
                w_ram_wdata = r_smp;
            end
            S_TAP: begin
                w_ram_addr = w_tap_addr;
            end
            default: begin
                if (w_avs_wr) begin
                    w_ram_we = 1'b1;
                    w_ram_be = avs_byteenable;
                end else begin
                    w_ram_we = 1'b0;
                end
            end
        endcase
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (w_ram_we && w_ram_be[b]) begin
                r_mem[w_ram_addr][b*8 +: 8] <= w_ram_wdata[b*8 +: 8];
            end
        end
    end

    // Sequencer state, captured sample context and registered read outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_k         <= {TAP_IW{1'b0}};
            r_wr_ptr    <= {ADDR_W{1'b0}};
            r_smp       <= {DATA_W{1'b0}};
            for (int t = 0; t < NUM_TAPS; t++) begin
                r_delay[t] <= {ADDR_W{1'b0}};
            end
            r_tap_valid <= 1'b0;
            r_tap_index <= {TAP_IW{1'b0}};
            r_tap_data  <= {DATA_W{1'b0}};
            r_avs_rdv   <= 1'b0;
            r_avs_rdata <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && smp_valid) begin
                r_smp <= smp_data;
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_delay[t] <= tap_delay[t*ADDR_W +: ADDR_W];
                end
            end
            case (r_state)
                S_WR:    r_k      <= {TAP_IW{1'b0}};
                S_TAP:   r_k      <= r_k + TAP_IW'(1);
                S_DONE:  r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                default: r_k      <= r_k;
            endcase
            r_tap_valid <= w_tap_rd;
            if (w_tap_rd) begin
                r_tap_data  <= r_mem[w_ram_addr];
                r_tap_index <= r_k;
            end
            r_avs_rdv <= w_avs_rd;
            if (w_avs_rd) begin
                r_avs_rdata <= r_mem[w_ram_addr];
            end
        end
    end

endmodule
